pixel_fb_writer: RTL and testbench

- Consumer end of the sprite pixel stream (plot / X / Y / colour) emitted by the bird and crosshair datapaths.
- Buffers incoming pixel writes in a small FIFO, clips any pixel outside the 160x120 screen, and converts each pixel to a linear framebuffer address.
- Writes pixels into the shared 3-bit framebuffer RAM through a ready/we handshake, since scan-out can stall the RAM.
- Also runs a full-screen clear, requested by the game FSM between rounds.

---
 rtl/fb_pkg.sv | 31 +++
 rtl/pixel_fifo.sv | 53 +++++
 rtl/pixel_fb_writer.sv | 192 +++++++++++++++++++
 tb/tb_pixel_fb_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the sprite framebuffer writer.
// Screen geometry, framebuffer widths, FSM states and the pixel bundle.
package fb_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;
  localparam int COLOUR_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOUR_W-1:0]  colour;
  } fb_pixel_t;

  // y*160 + x built from shifts so no multiplier is needed
  function automatic logic [FB_ADDR_W-1:0] pix_addr(
    input logic [7:0] x,
    input logic [6:0] y
  );
    logic [FB_ADDR_W-1:0] yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding pending pixel writes.
// Caller only pushes when there is room (or a pop frees it) and pops when non-empty.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;

  // pointer and occupancy update; power-of-2 depth wraps naturally
  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage; contents need no reset since occupancy gates them
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/pixel_fb_writer.sv
// Sprite pixel stream to framebuffer writer with clipping and screen clear.
// Optional clip statistics counter built only when FB_CLIP_STATS_EN is defined.
module pixel_fb_writer
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = fb_pkg::SCREEN_W,
  parameter int SCREEN_H   = fb_pkg::SCREEN_H
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 plot,
  input  logic [7:0]           x_in,
  input  logic [6:0]           y_in,
  input  logic [COLOUR_W-1:0]  colour_in,
  input  logic                 clear_req,
  input  logic [COLOUR_W-1:0]  clear_colour,
  input  logic                 mem_ready,
  output logic                 mem_we,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic [COLOUR_W-1:0]  mem_data,
  output logic                 busy,
  output logic                 clear_done,
  output logic                 overflow,
  output logic [7:0]           clip_count
);

  localparam logic [7:0] X_LIM = 8'(SCREEN_W);
  localparam logic [6:0] Y_LIM = 7'(SCREEN_H);
  localparam logic [FB_ADDR_W-1:0] LAST =
    FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

  fb_state_e state_q, state_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [COLOUR_W-1:0] data_q, data_d;
  logic we_q, we_d;
  logic pend_q, pend_d;
  logic [COLOUR_W-1:0] pcol_q, pcol_d;
  logic done_q, done_d;
  logic ovf_q, ovf_d;

  fb_pixel_t in_px, head_px;
  logic in_range, px_ok, push, pop, full, empty;
  logic clr_any, start_clr, load, accept;
  logic [COLOUR_W-1:0] clr_col;

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W($bits(fb_pixel_t))
  ) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din(in_px),
    .dout(head_px),
    .full(full),
    .empty(empty)
  );

  // input stage: clip, address, push; a same-cycle pop makes room first
  always_comb begin
    in_range     = (x_in < X_LIM) && (y_in < Y_LIM);
    px_ok        = plot & in_range;
    in_px.addr   = pix_addr(x_in, y_in);
    in_px.colour = colour_in;
    push         = px_ok & (~full | pop);
    ovf_d        = ovf_q | (px_ok & full & ~pop);
  end

  // write/clear sequencer; clear takes priority over queued pixels
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = we_q;
    pend_d    = pend_q;
    pcol_d    = pcol_q;
    done_d    = 1'b0;
    start_clr = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    clr_any   = pend_q | clear_req;
    clr_col   = pend_q ? pcol_q : clear_colour;
    accept    = we_q & mem_ready;
    unique case (state_q)
      IDLE: begin
        if (clr_any) start_clr = 1'b1;
        else if (!empty) load = 1'b1;
      end
      WRITE: begin
        if (accept) begin
          if (clr_any) start_clr = 1'b1;
          else if (!empty) load = 1'b1;
          else begin
            we_d    = 1'b0;
            state_d = IDLE;
          end
        end else if (clear_req && !pend_q) begin
          pend_d = 1'b1;
          pcol_d = clear_colour;
        end
      end
      CLEAR: begin
        if (clear_req && !pend_q) begin
          pend_d = 1'b1;
          pcol_d = clear_colour;
        end
        if (mem_ready) begin
          if (addr_q == LAST) begin
            done_d = 1'b1;
            if (clr_any) start_clr = 1'b1;
            else if (!empty) load = 1'b1;
            else begin
              we_d    = 1'b0;
              state_d = IDLE;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (start_clr) begin
      state_d = CLEAR;
      addr_d  = '0;
      data_d  = clr_col;
      we_d    = 1'b1;
      pend_d  = 1'b0;
    end else if (load) begin
      pop     = 1'b1;
      addr_d  = head_px.addr;
      data_d  = head_px.colour;
      we_d    = 1'b1;
      state_d = WRITE;
    end
  end

  // sequencer and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      pcol_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      pcol_q  <= pcol_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FB_CLIP_STATS_EN
  logic [7:0] clip_q, clip_d;

  // saturating count of off-screen plots
  always_comb begin
    clip_d = clip_q + 8'(plot & ~in_range & (clip_q != 8'hFF));
  end

  // clip counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clip_q <= '0;
    else clip_q <= clip_d;
  end

  assign clip_count = clip_q;
`else
  assign clip_count = '0;
`endif

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign clear_done = done_q;
  assign overflow   = ovf_q;
  assign busy       = ~empty | (state_q != IDLE) | pend_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Scoreboard bench for pixel_fb_writer.
// Expected writes are queued by stimulus; a monitor checks each accepted write.
module tb_pixel_fb_writer;

  logic clk = 1'b0;
  logic reset_n;
  logic plot;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic clear_req;
  logic [2:0] clear_colour;
  logic mem_ready;
  logic mem_we;
  logic [14:0] mem_addr;
  logic [2:0] mem_data;
  logic busy;
  logic clear_done;
  logic overflow;
  logic [7:0] clip_count;

  int checks = 0;
  int errors = 0;
  int cdone_n = 0;
  logic [17:0] sbq[$];

  always #5 clk = ~clk;

  pixel_fb_writer #(.FIFO_DEPTH(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .plot(plot),
    .x_in(x_in),
    .y_in(y_in),
    .colour_in(colour_in),
    .clear_req(clear_req),
    .clear_colour(clear_colour),
    .mem_ready(mem_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .busy(busy),
    .clear_done(clear_done),
    .overflow(overflow),
    .clip_count(clip_count)
  );

  // monitor: every accepted write must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n && mem_we && mem_ready) begin
      logic [17:0] e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr %0d data %0d",
                 mem_addr, mem_data);
      end else begin
        e = sbq.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL write got addr %0d data %0d want addr %0d data %0d",
                   mem_addr, mem_data, e[17:3], e[2:0]);
        end
      end
    end
    if (clear_done) cdone_n++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic expect_wr(input int a, input int c);
    sbq.push_back({15'(a), 3'(c)});
  endtask

  task automatic send(input int x, input int y, input int c);
    plot = 1'b1;
    x_in = 8'(x);
    y_in = 7'(y);
    colour_in = 3'(c);
    tick();
    plot = 1'b0;
  endtask

  task automatic pulse_clear(input int c);
    clear_req = 1'b1;
    clear_colour = 3'(c);
    tick();
    clear_req = 1'b0;
  endtask

  // bounded wait for the scoreboard to empty
  task automatic wait_q(input string nm, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_drain"}, sbq.size(), 0);
  endtask

  // bounded wait for the DUT to go idle
  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_addr(input int a, input int budget);
    int n = 0;
    while (mem_addr != 15'(a) && n < budget) begin
      tick();
      n++;
    end
    chk("reach_addr", int'(mem_addr), a);
  endtask

  initial begin
    int c0;
    reset_n = 1'b0;
    plot = 1'b0;
    x_in = '0;
    y_in = '0;
    colour_in = '0;
    clear_req = 1'b0;
    clear_colour = '0;
    mem_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // reset state
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(mem_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(clear_done), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_clip", int'(clip_count), 0);

    // single pixel (80,60): 60*160+80 = 9680
    expect_wr(9680, 7);
    send(80, 60, 7);
    chk("single_we_n", int'(mem_we), 0);
    chk("single_busy", int'(busy), 1);
    tick();
    chk("single_we_n1", int'(mem_we), 1);
    chk("single_addr", int'(mem_addr), 9680);
    tick();
    chk("single_we_off", int'(mem_we), 0);
    chk("single_busy_off", int'(busy), 0);

    // 4x4 burst at (158,118): 19038, 19039, 19198, 19199 survive
    expect_wr(19038, 1);
    expect_wr(19039, 2);
    expect_wr(19198, 1);
    expect_wr(19199, 2);
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        send(158 + dx, 118 + dy, 1 + (dx % 2));
    wait_q("burst", 50);
    wait_idle("burst", 20);
`ifdef FB_CLIP_STATS_EN
    chk("burst_clip", int'(clip_count), 12);
`else
    chk("burst_clip", int'(clip_count), 0);
`endif
    chk("burst_ovf", int'(overflow), 0);

    // backpressure: pixel 0 is presented, eight more fit behind it,
    // pixel 9 is dropped
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) expect_wr(160 + i, i % 8);
    for (int i = 0; i < 10; i++) begin
      send(i, 1, i % 8);
      if (i >= 1) chk("bp_addr_hold", int'(mem_addr), 160);
    end
    tick();
    chk("bp_ovf", int'(overflow), 1);
    chk("bp_we", int'(mem_we), 1);
    chk("bp_data_hold", int'(mem_data), 0);
    mem_ready = 1'b1;
    wait_q("bp", 40);
    wait_idle("bp", 20);
    chk("bp_ovf_sticky", int'(overflow), 1);

    // full clear with colour 3
    for (int a = 0; a < 19200; a++) expect_wr(a, 3);
    c0 = cdone_n;
    pulse_clear(3);
    chk("clr_busy", int'(busy), 1);
    wait_q("clr", 19300);
    chk("clr_done_pulse", int'(clear_done), 1);
    chk("clr_busy_end", int'(busy), 0);
    tick();
    chk("clr_done_low", int'(clear_done), 0);
    chk("clr_done_count", cdone_n - c0, 1);

    // pixel (5,5) during clear lands after address 19199
    for (int a = 0; a < 19200; a++) expect_wr(a, 5);
    expect_wr(805, 6);
    pulse_clear(5);
    wait_addr(100, 300);
    send(5, 5, 6);
    chk("mid_busy", int'(busy), 1);
    wait_q("mid", 19300);
    wait_idle("mid", 10);

    // async reset mid-clear at address 500
    for (int a = 0; a < 500; a++) expect_wr(a, 2);
    c0 = cdone_n;
    pulse_clear(2);
    wait_addr(500, 700);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_we", int'(mem_we), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ovf", int'(overflow), 0);
    chk("rst_mid_sb", sbq.size(), 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("rst_mid_nodone", cdone_n - c0, 0);

    // normal pixel after reset: (10,2) -> 330
    expect_wr(330, 4);
    send(10, 2, 4);
    wait_q("post", 20);
    wait_idle("post", 10);
    chk("final_sb", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
